// File: rtl/kf8259_inta_initiator.sv
// CPU-side 8259 interrupt-acknowledge sequencer: drives INTA_n pulses, captures the vector or CALL target.
// Optional opcode check of the MCS-80 first byte is built when KF8259_INTA_OPCODE_CHECK_EN is defined.
module kf8259_inta_initiator #(
   parameter int INTA_LOW_CYCLES = 2,
   parameter int INTA_GAP_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        interrupt_request,
   input  logic        interrupt_enable,
   input  logic        mcs80_mode,
   input  logic [7:0]  data_bus_in,
   input  logic        vector_accept,
   output logic        interrupt_acknowledge_n,
   output logic        sequence_busy,
   output logic        vector_valid,
   output logic [7:0]  vector_data,
   output logic [15:0] call_address,
   output logic        opcode_error
);

   typedef enum logic [1:0] {
      IDLE,
      PULSE_LOW,
      PULSE_GAP,
      DONE
   } state_t;

   localparam logic [7:0] LOW_LAST = 8'(INTA_LOW_CYCLES - 1);
   localparam logic [7:0] GAP_LAST = 8'(INTA_GAP_CYCLES - 1);

   state_t      state, state_next;
   logic [7:0]  cycle_count, cycle_count_next;
   logic [1:0]  pulse_count, pulse_count_next;
   logic        mode_latched, mode_latched_next;
   logic [7:0]  vector_next;
   logic [15:0] call_next;
   logic        last_low, last_gap, final_pulse;

   assign last_low    = (cycle_count == LOW_LAST);
   assign last_gap    = (cycle_count == GAP_LAST);
   assign final_pulse = mode_latched ? (pulse_count == 2'd2) : (pulse_count == 2'd1);

   always_comb begin
      state_next        = state;
      cycle_count_next  = cycle_count;
      pulse_count_next  = pulse_count;
      mode_latched_next = mode_latched;
      vector_next       = vector_data;
      call_next         = call_address;
      case (state)
         IDLE: begin
            if (interrupt_request && interrupt_enable) begin
               state_next        = PULSE_LOW;
               cycle_count_next  = 8'd0;
               pulse_count_next  = 2'd0;
               mode_latched_next = mcs80_mode;
            end
         end
         PULSE_LOW: begin
            // The bus is only trusted on the final low cycle of each pulse.
            if (last_low) begin
               cycle_count_next = 8'd0;
               state_next       = final_pulse ? DONE : PULSE_GAP;
               if (mode_latched) begin
                  if (pulse_count == 2'd1)
                     call_next[7:0] = data_bus_in;
                  else if (pulse_count == 2'd2)
                     call_next[15:8] = data_bus_in;
               end else if (pulse_count == 2'd1) begin
                  vector_next = data_bus_in;
               end
            end else begin
               cycle_count_next = cycle_count + 8'd1;
            end
         end
         PULSE_GAP: begin
            if (last_gap) begin
               cycle_count_next = 8'd0;
               pulse_count_next = pulse_count + 2'd1;
               state_next       = PULSE_LOW;
            end else begin
               cycle_count_next = cycle_count + 8'd1;
            end
         end
         DONE: begin
            if (vector_accept)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state                   <= IDLE;
         cycle_count             <= 8'd0;
         pulse_count             <= 2'd0;
         mode_latched            <= 1'b0;
         interrupt_acknowledge_n <= 1'b1;
         sequence_busy           <= 1'b0;
         vector_valid            <= 1'b0;
         vector_data             <= 8'd0;
         call_address            <= 16'd0;
      end else begin
         state                   <= state_next;
         cycle_count             <= cycle_count_next;
         pulse_count             <= pulse_count_next;
         mode_latched            <= mode_latched_next;
         interrupt_acknowledge_n <= (state_next != PULSE_LOW);
         sequence_busy           <= (state_next != IDLE);
         vector_valid            <= (state_next == DONE);
         vector_data             <= vector_next;
         call_address            <= call_next;
      end
   end

`ifdef KF8259_INTA_OPCODE_CHECK_EN
   // Sticky until the core takes the result; the sequence completes regardless.
   always_ff @(posedge clock) begin
      if (reset)
         opcode_error <= 1'b0;
      else if (state == DONE && vector_accept)
         opcode_error <= 1'b0;
      else if (state == PULSE_LOW && last_low && mode_latched &&
               pulse_count == 2'd0 && data_bus_in != 8'hCD)
         opcode_error <= 1'b1;
   end
`else
   assign opcode_error = 1'b0;
`endif

endmodule
